// File: rtl/instr_encoder_pkg.sv
// Shared encoding tables for instr_encoder: RV32I opcodes, funct7 variants,
// instruction formats and the control-ROM operation index map.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FmtR, FmtI, FmtShift, FmtS, FmtB, FmtU, FmtJ, FmtNone
  } fmt_e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  // Control-ROM indices; anything above OpJalr is undefined.
  localparam logic [5:0] OpAdd  = 6'd0,  OpSub  = 6'd1,  OpSll  = 6'd2,  OpSlt   = 6'd3;
  localparam logic [5:0] OpSltu = 6'd4,  OpXor  = 6'd5,  OpSrl  = 6'd6,  OpSra   = 6'd7;
  localparam logic [5:0] OpOr   = 6'd8,  OpAnd  = 6'd9,  OpAddi = 6'd10, OpSlti  = 6'd11;
  localparam logic [5:0] OpSltiu = 6'd12, OpXori = 6'd13, OpOri = 6'd14, OpAndi = 6'd15;
  localparam logic [5:0] OpSlli = 6'd16, OpSrli = 6'd17, OpSrai = 6'd18, OpLb    = 6'd19;
  localparam logic [5:0] OpLh   = 6'd20, OpLw   = 6'd21, OpLbu  = 6'd22, OpLhu   = 6'd23;
  localparam logic [5:0] OpSb   = 6'd24, OpSh   = 6'd25, OpSw   = 6'd26, OpBeq   = 6'd27;
  localparam logic [5:0] OpBne  = 6'd28, OpBlt  = 6'd29, OpBge  = 6'd30, OpBltu  = 6'd31;
  localparam logic [5:0] OpBgeu = 6'd32, OpLui  = 6'd33, OpAuipc = 6'd34, OpJal  = 6'd35;
  localparam logic [5:0] OpJalr = 6'd36;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } op_info_t;

  function automatic op_info_t op_decode(input logic [5:0] op);
    op_info_t info;
    info = '{fmt: FmtNone, opcode: 7'd0, funct3: 3'd0, funct7: Funct7Base};
    case (op)
      OpAdd:   info = '{FmtR, OpcOp, 3'b000, Funct7Base};
      OpSub:   info = '{FmtR, OpcOp, 3'b000, Funct7Alt};
      OpSll:   info = '{FmtR, OpcOp, 3'b001, Funct7Base};
      OpSlt:   info = '{FmtR, OpcOp, 3'b010, Funct7Base};
      OpSltu:  info = '{FmtR, OpcOp, 3'b011, Funct7Base};
      OpXor:   info = '{FmtR, OpcOp, 3'b100, Funct7Base};
      OpSrl:   info = '{FmtR, OpcOp, 3'b101, Funct7Base};
      OpSra:   info = '{FmtR, OpcOp, 3'b101, Funct7Alt};
      OpOr:    info = '{FmtR, OpcOp, 3'b110, Funct7Base};
      OpAnd:   info = '{FmtR, OpcOp, 3'b111, Funct7Base};
      OpAddi:  info = '{FmtI, OpcOpImm, 3'b000, Funct7Base};
      OpSlti:  info = '{FmtI, OpcOpImm, 3'b010, Funct7Base};
      OpSltiu: info = '{FmtI, OpcOpImm, 3'b011, Funct7Base};
      OpXori:  info = '{FmtI, OpcOpImm, 3'b100, Funct7Base};
      OpOri:   info = '{FmtI, OpcOpImm, 3'b110, Funct7Base};
      OpAndi:  info = '{FmtI, OpcOpImm, 3'b111, Funct7Base};
      OpSlli:  info = '{FmtShift, OpcOpImm, 3'b001, Funct7Base};
      OpSrli:  info = '{FmtShift, OpcOpImm, 3'b101, Funct7Base};
      OpSrai:  info = '{FmtShift, OpcOpImm, 3'b101, Funct7Alt};
      OpLb:    info = '{FmtI, OpcLoad, 3'b000, Funct7Base};
      OpLh:    info = '{FmtI, OpcLoad, 3'b001, Funct7Base};
      OpLw:    info = '{FmtI, OpcLoad, 3'b010, Funct7Base};
      OpLbu:   info = '{FmtI, OpcLoad, 3'b100, Funct7Base};
      OpLhu:   info = '{FmtI, OpcLoad, 3'b101, Funct7Base};
      OpSb:    info = '{FmtS, OpcStore, 3'b000, Funct7Base};
      OpSh:    info = '{FmtS, OpcStore, 3'b001, Funct7Base};
      OpSw:    info = '{FmtS, OpcStore, 3'b010, Funct7Base};
      OpBeq:   info = '{FmtB, OpcBranch, 3'b000, Funct7Base};
      OpBne:   info = '{FmtB, OpcBranch, 3'b001, Funct7Base};
      OpBlt:   info = '{FmtB, OpcBranch, 3'b100, Funct7Base};
      OpBge:   info = '{FmtB, OpcBranch, 3'b101, Funct7Base};
      OpBltu:  info = '{FmtB, OpcBranch, 3'b110, Funct7Base};
      OpBgeu:  info = '{FmtB, OpcBranch, 3'b111, Funct7Base};
      OpLui:   info = '{FmtU, OpcLui, 3'b000, Funct7Base};
      OpAuipc: info = '{FmtU, OpcAuipc, 3'b000, Funct7Base};
      OpJal:   info = '{FmtJ, OpcJal, 3'b000, Funct7Base};
      OpJalr:  info = '{FmtI, OpcJalr, 3'b000, Funct7Base};
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational fields-to-word packer for RV32I formats.
// ENC_IMM_RANGE_CHECK_EN enables immediate range checking (imm_ok_o).
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        op_ok_o,
  output logic        imm_ok_o
);

  op_info_t info;

  assign info    = op_decode(op_i);
  assign op_ok_o = (info.fmt != FmtNone);

  always_comb begin
    word_o = '0;
    case (info.fmt)
      FmtR:     word_o = {info.funct7, rs2_i, rs1_i, info.funct3, rd_i, info.opcode};
      FmtI:     word_o = {imm_i[11:0], rs1_i, info.funct3, rd_i, info.opcode};
      FmtShift: word_o = {info.funct7, imm_i[4:0], rs1_i, info.funct3, rd_i, info.opcode};
      FmtS:     word_o = {imm_i[11:5], rs2_i, rs1_i, info.funct3, imm_i[4:0], info.opcode};
      FmtB:     word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, info.funct3, imm_i[4:1],
                          imm_i[11], info.opcode};
      FmtU:     word_o = {imm_i[31:12], rd_i, info.opcode};
      FmtJ:     word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, info.opcode};
      default:  word_o = '0;
    endcase
  end

`ifdef ENC_IMM_RANGE_CHECK_EN
  // Upper bits must be a pure sign extension of the field; B/J offsets must be even.
  always_comb begin
    imm_ok_o = 1'b1;
    case (info.fmt)
      FmtI, FmtS: imm_ok_o = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      FmtShift:   imm_ok_o = ~(|imm_i[31:5]);
      FmtB:       imm_ok_o = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
      FmtJ:       imm_ok_o = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
      FmtU:       imm_ok_o = ~(|imm_i[11:0]);
      default:    imm_ok_o = 1'b1;
    endcase
  end
`else
  assign imm_ok_o = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder writing one instruction word per cycle into IMEM.
// ENC_IMM_RANGE_CHECK_EN (in instr_pack) drops words with out-of-range immediates.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned IMEM_AW   = 14,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [5:0]         in_op_i,
  input  logic [4:0]         in_rd_i,
  input  logic [4:0]         in_rs1_i,
  input  logic [4:0]         in_rs2_i,
  input  logic [31:0]        in_imm_i,
  output logic [3:0]         imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_din_o,
  output logic [IMEM_AW:0]   count_o,
  output logic               full_o,
  output logic               err_o
);

  localparam logic [IMEM_AW-1:0] BaseAddr = IMEM_AW'(BASE_ADDR);

  state_e             state_q, state_d;
  logic               s1_valid_q;
  logic [5:0]         s1_op_q;
  logic [4:0]         s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [31:0]        s1_imm_q;
  logic               we_q;
  logic [31:0]        din_q;
  logic [IMEM_AW-1:0] ptr_q;
  logic [IMEM_AW:0]   count_q;
  logic               err_q;

  logic               accept, s1_wr, op_ok, imm_ok, room_ok;
  logic [31:0]        pack_word;
  logic [IMEM_AW:0]   fill;

  instr_pack u_pack (
    .op_i     (s1_op_q),
    .rd_i     (s1_rd_q),
    .rs1_i    (s1_rs1_q),
    .rs2_i    (s1_rs2_q),
    .imm_i    (s1_imm_q),
    .word_o   (pack_word),
    .op_ok_o  (op_ok),
    .imm_ok_o (imm_ok)
  );

  assign s1_wr  = s1_valid_q & op_ok & imm_ok;
  // Addresses already claimed by words still in the pipe; bit IMEM_AW set means none left.
  assign fill    = {1'b0, ptr_q} + {{IMEM_AW{1'b0}}, we_q} + {{IMEM_AW{1'b0}}, s1_wr};
  assign room_ok = ~fill[IMEM_AW];
  assign accept  = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = StRun;
    end else if (state_q == StRun && we_q && (&ptr_q)) begin
      state_d = StDone;
    end
  end

  always_comb begin
    in_ready_o = 1'b0;
    full_o     = 1'b0;
    unique case (state_q)
      StRun:   in_ready_o = room_ok & ~start_i;
      StDone:  full_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
    end else begin
      s1_valid_q <= accept & ~start_i;
      if (accept) begin
        s1_op_q  <= in_op_i;
        s1_rd_q  <= in_rd_i;
        s1_rs1_q <= in_rs1_i;
        s1_rs2_q <= in_rs2_i;
        s1_imm_q <= in_imm_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      din_q   <= '0;
      ptr_q   <= BaseAddr;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (start_i) begin
      we_q    <= 1'b0;
      ptr_q   <= BaseAddr;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= s1_wr;
      if (s1_wr) din_q <= pack_word;
      if (s1_valid_q && !(op_ok && imm_ok)) err_q <= 1'b1;
      if (we_q) begin
        ptr_q   <= ptr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

  // A start pulse cancels the word currently on the write port.
  assign imem_we_o   = {4{we_q & ~start_i}};
  assign imem_addr_o = ptr_q;
  assign imem_din_o  = din_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule
